// File: rtl/nibble_pkg.sv
// Shared types and constants for the nibble-serial adder master.
// Holds the nibble width, the FSM state encoding and the index-width helper.
package nibble_pkg;

    localparam int NIBBLE_W = 4;

    typedef logic [NIBBLE_W-1:0] nibble_t;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    // Index counter width, never narrower than one bit so NIBBLES=1 still has a flop.
    function automatic int idx_width(input int n);
        if (n <= 1) begin
            return 1;
        end else begin
            return $clog2(n);
        end
    endfunction

endpackage

// File: rtl/nibble_add.sv
// Single 4-bit ripple adder slice shared by every nibble of the serial add.
module nibble_add
    import nibble_pkg::*;
(
    input  logic [NIBBLE_W-1:0] a,
    input  logic [NIBBLE_W-1:0] b,
    input  logic                ci,
    output logic [NIBBLE_W-1:0] s,
    output logic                co
);

    assign {co, s} = {1'b0, a} + {1'b0, b} + {{NIBBLE_W{1'b0}}, ci};

endmodule

// File: rtl/nibble_add_master.sv
// Nibble-serial adder: accepts an operand pair, adds one nibble per cycle through
// a single shared 4-bit adder, then holds the registered result until consumed.
module nibble_add_master
    import nibble_pkg::*;
#(
    parameter int NIBBLES = 4
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         in_valid,
    output logic                         in_ready,
    input  logic [NIBBLE_W*NIBBLES-1:0]  op_a,
    input  logic [NIBBLE_W*NIBBLES-1:0]  op_b,
    input  logic                         cin,
    output logic                         out_valid,
    input  logic                         out_ready,
    output logic [NIBBLE_W*NIBBLES-1:0]  sum,
    output logic                         cout
);

    localparam int IDX_W = idx_width(NIBBLES);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NIBBLES - 1);

    state_t                    state_q, state_d;
    logic [IDX_W-1:0]          idx_q, idx_d;
    logic                      carry_q, carry_d;
    nibble_t [NIBBLES-1:0]     a_q, a_d;
    nibble_t [NIBBLES-1:0]     b_q, b_d;
    nibble_t [NIBBLES-1:0]     sum_q, sum_d;
    logic                      cout_q, cout_d;
    logic                      in_ready_q, in_ready_d;
    logic                      out_valid_q, out_valid_d;

    nibble_t                   add_s;
    logic                      add_co;

    nibble_add u_nibble_add (
        .a  (a_q[idx_q]),
        .b  (b_q[idx_q]),
        .ci (carry_q),
        .s  (add_s),
        .co (add_co)
    );

    // Next-state and datapath update for the IDLE/RUN/DONE sequence.
    always_comb begin
        state_d     = state_q;
        idx_d       = idx_q;
        carry_d     = carry_q;
        a_d         = a_q;
        b_d         = b_q;
        sum_d       = sum_q;
        cout_d      = cout_q;
        in_ready_d  = in_ready_q;
        out_valid_d = out_valid_q;
        case (state_q)
            IDLE: begin
                if (in_valid) begin
                    a_d        = op_a;
                    b_d        = op_b;
                    carry_d    = cin;
                    idx_d      = {IDX_W{1'b0}};
                    state_d    = RUN;
                    in_ready_d = 1'b0;
                end else begin
                    in_ready_d  = 1'b1;
                    out_valid_d = 1'b0;
                end
            end
            RUN: begin
                sum_d[idx_q] = add_s;
                carry_d      = add_co;
                if (idx_q == LAST_IDX) begin
                    idx_d       = {IDX_W{1'b0}};
                    cout_d      = add_co;
                    out_valid_d = 1'b1;
                    state_d     = DONE;
                end else begin
                    idx_d = idx_q + IDX_W'(1);
                end
            end
            DONE: begin
                if (out_ready) begin
                    out_valid_d = 1'b0;
                    in_ready_d  = 1'b1;
                    state_d     = IDLE;
                end else begin
                    out_valid_d = 1'b1;
                end
            end
            default: begin
                state_d     = IDLE;
                idx_d       = {IDX_W{1'b0}};
                in_ready_d  = 1'b1;
                out_valid_d = 1'b0;
            end
        endcase
    end

    // State and output registers; reset wins over every other input.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            idx_q       <= {IDX_W{1'b0}};
            carry_q     <= 1'b0;
            a_q         <= '0;
            b_q         <= '0;
            sum_q       <= '0;
            cout_q      <= 1'b0;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            idx_q       <= idx_d;
            carry_q     <= carry_d;
            a_q         <= a_d;
            b_q         <= b_d;
            sum_q       <= sum_d;
            cout_q      <= cout_d;
            in_ready_q  <= in_ready_d;
            out_valid_q <= out_valid_d;
        end
    end

    assign in_ready  = in_ready_q;
    assign out_valid = out_valid_q;
    assign sum       = sum_q;
    assign cout      = cout_q;

endmodule

// File: tb/tb_nibble_add_master.sv
// Scoreboard bench for nibble_add_master: a 4-nibble instance for the main
// scenarios and a 1-nibble instance for the single-nibble case.
module tb_nibble_add_master;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        in_valid = 1'b0, cin = 1'b0, out_ready = 1'b0;
    logic [15:0] op_a = 16'h0, op_b = 16'h0;
    logic        in_ready, out_valid, cout;
    logic [15:0] sum;

    logic        in_valid1 = 1'b0, cin1 = 1'b0, out_ready1 = 1'b0;
    logic [3:0]  op_a1 = 4'h0, op_b1 = 4'h0;
    logic        in_ready1, out_valid1, cout1;
    logic [3:0]  sum1;

    logic [16:0] sb[$];
    int          n_cmp = 0;
    int          n_bad = 0;

    always #5 clk = ~clk;

    nibble_add_master #(.NIBBLES(4)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .op_a(op_a), .op_b(op_b), .cin(cin), .out_valid(out_valid),
        .out_ready(out_ready), .sum(sum), .cout(cout)
    );

    nibble_add_master #(.NIBBLES(1)) dut1 (
        .clk(clk), .rst(rst), .in_valid(in_valid1), .in_ready(in_ready1),
        .op_a(op_a1), .op_b(op_b1), .cin(cin1), .out_valid(out_valid1),
        .out_ready(out_ready1), .sum(sum1), .cout(cout1)
    );

    // Drive one accept on the 4-nibble DUT, push the model result, return at the negedge after the accept edge.
    task automatic accept(input logic [15:0] a, input logic [15:0] b, input logic c);
        @(negedge clk);
        in_valid = 1'b1; op_a = a; op_b = b; cin = c;
        sb.push_back({1'b0, a} + {1'b0, b} + {16'd0, c});
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
    endtask

    task automatic wait_out(output int edges);
        edges = 0;
        while (!out_valid && edges < 20) begin
            @(negedge clk);
            edges++;
        end
    endtask

    task automatic test_reset;
        rst = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        n_cmp++; if (out_valid !== 1'b0) begin n_bad++; $display("FAIL reset_out_valid got %b want 0", out_valid); end
        n_cmp++; if (in_ready !== 1'b1) begin n_bad++; $display("FAIL reset_in_ready got %b want 1", in_ready); end
        n_cmp++; if (sum !== 16'h0000) begin n_bad++; $display("FAIL reset_sum got %h want 0000", sum); end
        n_cmp++; if (cout !== 1'b0) begin n_bad++; $display("FAIL reset_cout got %b want 0", cout); end
    endtask

    task automatic test_zero;
        int edges;
        logic [16:0] exp;
        accept(16'h0000, 16'h0000, 1'b0);
        wait_out(edges);
        n_cmp++; if (edges !== 4) begin n_bad++; $display("FAIL zero_latency got %0d want 4", edges); end
        exp = sb.pop_front();
        n_cmp++; if ({cout, sum} !== exp) begin n_bad++; $display("FAIL zero_result got %h want %h", {cout, sum}, exp); end
        n_cmp++; if (exp !== 17'h00000) begin n_bad++; $display("FAIL zero_model got %h want 00000", exp); end
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        n_cmp++; if (out_valid !== 1'b0 || in_ready !== 1'b1) begin n_bad++; $display("FAIL zero_release got v=%b r=%b want v=0 r=1", out_valid, in_ready); end
    endtask

    // out_ready is held high throughout; it must not matter until out_valid rises.
    task automatic test_full_ripple;
        int edges;
        logic [16:0] exp;
        out_ready = 1'b1;
        accept(16'hFFFF, 16'h0001, 1'b0);
        wait_out(edges);
        n_cmp++; if (edges !== 4) begin n_bad++; $display("FAIL ripple_latency got %0d want 4", edges); end
        exp = sb.pop_front();
        n_cmp++; if ({cout, sum} !== exp || exp !== 17'h10000) begin n_bad++; $display("FAIL ripple_result got %h want %h", {cout, sum}, exp); end
        @(negedge clk);
        out_ready = 1'b0;
        n_cmp++; if (out_valid !== 1'b0 || in_ready !== 1'b1) begin n_bad++; $display("FAIL ripple_release got v=%b r=%b want v=0 r=1", out_valid, in_ready); end
    endtask

    task automatic test_operand_change;
        int edges;
        logic [16:0] exp;
        accept(16'h7E5A, 16'h1234, 1'b1);
        in_valid = 1'b1; op_a = 16'hAAAA; op_b = 16'hAAAA; cin = 1'b0;
        n_cmp++; if (in_ready !== 1'b0) begin n_bad++; $display("FAIL change_in_ready got %b want 0", in_ready); end
        wait_out(edges);
        in_valid = 1'b0;
        n_cmp++; if (edges !== 4) begin n_bad++; $display("FAIL change_latency got %0d want 4", edges); end
        exp = sb.pop_front();
        n_cmp++; if ({cout, sum} !== exp || exp !== 17'h0908F) begin n_bad++; $display("FAIL change_result got %h want %h", {cout, sum}, exp); end
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        n_cmp++; if (out_valid !== 1'b0 || in_ready !== 1'b1) begin n_bad++; $display("FAIL change_release got v=%b r=%b", out_valid, in_ready); end
    endtask

    task automatic test_hold;
        int edges;
        logic [16:0] exp;
        accept(16'hFFFF, 16'hFFFF, 1'b1);
        wait_out(edges);
        n_cmp++; if (edges !== 4) begin n_bad++; $display("FAIL hold_latency got %0d want 4", edges); end
        exp = sb.pop_front();
        for (int i = 0; i < 3; i++) begin
            n_cmp++;
            if ({cout, sum} !== exp || out_valid !== 1'b1 || in_ready !== 1'b0) begin
                n_bad++;
                $display("FAIL hold_cycle%0d got %h v=%b r=%b want %h v=1 r=0", i, {cout, sum}, out_valid, in_ready, exp);
            end
            @(negedge clk);
        end
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        n_cmp++; if (out_valid !== 1'b0 || in_ready !== 1'b1) begin n_bad++; $display("FAIL hold_release got v=%b r=%b want v=0 r=1", out_valid, in_ready); end
    endtask

    task automatic test_reset_mid_run;
        int edges;
        int seen;
        logic [16:0] exp;
        accept(16'h1111, 16'h2222, 1'b0);
        void'(sb.pop_back());
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        n_cmp++; if (in_ready !== 1'b1 || out_valid !== 1'b0) begin n_bad++; $display("FAIL abort_state got r=%b v=%b want r=1 v=0", in_ready, out_valid); end
        seen = 0;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            if (out_valid) seen++;
        end
        n_cmp++; if (seen !== 0) begin n_bad++; $display("FAIL abort_no_result got %0d valid cycles want 0", seen); end
        accept(16'h0003, 16'h0004, 1'b0);
        wait_out(edges);
        exp = sb.pop_front();
        n_cmp++; if ({cout, sum} !== exp || exp !== 17'h00007) begin n_bad++; $display("FAIL abort_next got %h want %h", {cout, sum}, exp); end
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
    endtask

    task automatic test_single_nibble;
        int edges;
        logic [16:0] exp;
        @(negedge clk);
        in_valid1 = 1'b1; op_a1 = 4'hF; op_b1 = 4'h1; cin1 = 1'b1;
        sb.push_back({13'd0, {1'b0, op_a1} + {1'b0, op_b1} + {4'd0, cin1}});
        @(posedge clk);
        @(negedge clk);
        in_valid1 = 1'b0;
        edges = 0;
        while (!out_valid1 && edges < 20) begin
            @(negedge clk);
            edges++;
        end
        n_cmp++; if (edges !== 1) begin n_bad++; $display("FAIL single_latency got %0d want 1", edges); end
        exp = sb.pop_front();
        n_cmp++; if ({cout1, sum1} !== exp[4:0] || exp[4:0] !== 5'h11) begin n_bad++; $display("FAIL single_result got %h want %h", {cout1, sum1}, exp[4:0]); end
        out_ready1 = 1'b1;
        @(negedge clk);
        out_ready1 = 1'b0;
        n_cmp++; if (out_valid1 !== 1'b0 || in_ready1 !== 1'b1) begin n_bad++; $display("FAIL single_release got v=%b r=%b", out_valid1, in_ready1); end
    endtask

    initial begin
        test_reset;
        test_zero;
        test_full_ripple;
        test_operand_change;
        test_hold;
        test_reset_mid_run;
        test_single_nibble;
        n_cmp++; if (sb.size() !== 0) begin n_bad++; $display("FAIL scoreboard_drain got %0d left want 0", sb.size()); end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/nibble_add_master.md
NIBBLE_ADD_MASTER -- requirements
Module: nibble_add_master

Interface
REQ-001 The block SHALL have parameter NIBBLES, default 4, giving the number of 4-bit operand nibbles, legal range 1..8.
REQ-002 Port clk, input, 1 bit, is the single clock; all state SHALL update on its rising edge.
REQ-003 Port rst, input, 1 bit, is the reset; it SHALL be synchronous and active-high.
REQ-004 Port in_valid, input, 1 bit, means the requester offers an operand pair.
REQ-005 Port in_ready, output, 1 bit, means the block accepts an operand pair this cycle.
REQ-006 Port op_a, input, 4*NIBBLES bits, is operand A, unsigned.
REQ-007 Port op_b, input, 4*NIBBLES bits, is operand B, unsigned.
REQ-008 Port cin, input, 1 bit, is the carry into nibble 0.
REQ-009 Port out_valid, output, 1 bit, means the result is presented.
REQ-010 Port out_ready, input, 1 bit, means the consumer takes the result.
REQ-011 Port sum, output, 4*NIBBLES bits, is the result, registered.
REQ-012 Port cout, output, 1 bit, is the carry out of the top nibble, registered.

Function
REQ-013 The block SHALL be an FSM with exactly three states: IDLE, RUN and DONE.
REQ-014 In IDLE: in_ready=1 and out_valid=0.
REQ-015 When in_valid=1 in IDLE, the block SHALL complete an accept: latch op_a, op_b and cin, set nibble index idx=0, and go to RUN.
REQ-016 In RUN, each cycle SHALL add nibble idx of A and B plus the carry register through a single 4-bit adder.
- The 4-bit result goes to sum[4*idx+3:4*idx].
- The adder carry-out goes to the carry register.
- idx increments.
REQ-017 RUN SHALL go to DONE on the cycle that processes idx==NIBBLES-1; RUN lasts exactly NIBBLES cycles.
REQ-018 out_valid SHALL rise exactly NIBBLES clock edges after the accept edge, with cout equal to the final carry register.
REQ-019 In DONE: out_valid=1 and in_ready=0; sum and cout SHALL stay stable until out_ready=1.
REQ-020 DONE with out_ready=1 SHALL go to IDLE; at least one idle cycle separates consecutive accepts.
REQ-021 in_ready SHALL be 0 in RUN and DONE; in_valid, op_a, op_b and cin SHALL be ignored there.
REQ-022 Operand changes after the accept SHALL NOT affect the result.
REQ-023 The result SHALL equal (op_a + op_b + cin) mod 2^(4*NIBBLES), with cout the bit 4*NIBBLES carry; wrap-around is not an error.
REQ-024 out_ready while out_valid=0 SHALL have no effect.
REQ-025 idx width SHALL be clog2(NIBBLES), minimum 1 bit; idx SHALL never exceed NIBBLES-1.

Reset
REQ-026 rst=1 SHALL, on the next clock edge, force the state to IDLE and set idx, the carry register, sum, cout and out_valid to 0.
REQ-027 in_ready SHALL be 1 from the first cycle after reset.
REQ-028 rst SHALL take priority over every other input.
REQ-029 Reset during RUN or DONE SHALL abandon the operation with no result produced; the next accept SHALL start clean.

Structure
REQ-030 A shared package nibble_pkg SHALL hold:
- NIBBLE_W=4;
- the state enumeration typedef (IDLE, RUN, DONE);
- the nibble typedef (4-bit logic).
REQ-031 The 4-bit add SHALL be one combinational sub-module, nibble_add (a[3:0], b[3:0], ci -> s[3:0], co), instantiated once; per-nibble adders SHALL NOT be replicated.
REQ-032 The output datapath SHALL be fully registered; no combinational path from inputs to sum or cout.

Verification
REQ-033 Scenario 1: rst for 2 cycles, then op_a=0x0000, op_b=0x0000, cin=0 -> out_valid after 4 edges; sum=0x0000, cout=0.
REQ-034 Scenario 2: op_a=0xFFFF, op_b=0x0001, cin=0 -> sum=0x0000, cout=1 (full ripple across all nibbles).
REQ-035 Scenario 3: op_a=0x7E5A, op_b=0x1234, cin=1 -> sum=0x908F, cout=0; the operands change to 0xAAAA the cycle after accept and the result is unchanged.
REQ-036 Scenario 4: op_a=0xFFFF, op_b=0xFFFF, cin=1 with out_ready=0 for 3 cycles -> sum=0xFFFF, cout=1, held stable; in_ready=0 throughout; IDLE reached the cycle after out_ready=1.
REQ-037 Scenario 5: rst asserted at RUN cycle 2 of a 0x1111+0x2222 operation -> out_valid never asserts; in_ready=1 the cycle after reset; the next op 0x0003+0x0004 gives sum=0x0007.
REQ-038 Scenario 6: NIBBLES=1, op_a=0xF, op_b=0x1, cin=1 -> sum=0x1, cout=1, out_valid 1 edge after accept.
